// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and hazard unit: youngest-producer bypass
// select, long-latency countdown scoreboard and saturating stall counter.
module fwd_hazard_unit #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int LAT_W    = 4,
    parameter bit FWD_EN   = 1'b1,
    parameter int PERF_W   = 32,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_FWD-1:0]                stg_regWrite,
    input  logic [NUM_FWD-1:0][REG_W-1:0]     stg_rd,
    input  logic                              ex_valid,
    input  logic [NUM_SRC-1:0][REG_W-1:0]     ex_rs,
    input  logic [NUM_SRC-1:0]                ex_rs_used,
    input  logic                              mc_issue,
    input  logic [REG_W-1:0]                  mc_rd,
    input  logic [LAT_W-1:0]                  mc_lat,
    input  logic                              flush,
    output logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel,
    output logic                              stall,
    output logic [NUM_REGS-1:0]               sb_busy,
    output logic [PERF_W-1:0]                 stall_count
);

    logic [NUM_SRC-1:0][NUM_FWD-1:0] match;
    logic [LAT_W-1:0]                cnt_q [NUM_REGS];
    logic [LAT_W-1:0]                cnt_d [NUM_REGS];
    logic [PERF_W-1:0]               perf_q;
    logic [PERF_W-1:0]               perf_d;
    logic                            hz_stage;
    logic                            hz_sb;
    logic                            acc;

    always_comb begin
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                match[j][k] = stg_regWrite[k] && (stg_rd[k] != '0) &&
                              (stg_rd[k] == ex_rs[j]) && ex_rs_used[j];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            sb_busy[r] = (cnt_q[r] != '0);
        end
    end

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        hz_stage = 1'b0;
        hz_sb    = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            fwd_sel[j] = '0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (match[j][k]) begin
                    hz_stage = 1'b1;
                    if (FWD_EN) fwd_sel[j] = SEL_W'(k + 1);
                end
            end
            if (ex_rs_used[j] && (ex_rs[j] != '0) &&
                (int'(ex_rs[j]) < NUM_REGS) && sb_busy[ex_rs[j]]) begin
                hz_sb = 1'b1;
            end
        end
        hz_stage = hz_stage && ex_valid;
        hz_sb    = hz_sb && ex_valid;
    end

    assign stall = hz_sb || (!FWD_EN && hz_stage);

    assign acc = mc_issue && ex_valid && !stall && !flush &&
                 (mc_rd != '0) && (mc_lat != '0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0 || flush) begin
                cnt_d[r] = '0;
            end else if (acc && (mc_rd == REG_W'(r))) begin
                cnt_d[r] = mc_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (stall && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            perf_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            perf_q <= perf_d;
        end
    end

    assign stall_count = perf_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: one bypassing and one non-bypassing instance
// checked every cycle against a free-at-cycle model plus directed literals.
module tb_fwd_hazard_unit;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      stg_regWrite;
    logic [1:0][4:0] stg_rd;
    logic            ex_valid;
    logic [1:0][4:0] ex_rs;
    logic [1:0]      ex_rs_used;
    logic            mc_issue;
    logic [4:0]      mc_rd;
    logic [3:0]      mc_lat;
    logic            flush;

    logic [1:0][1:0] sel_a, sel_b;
    logic            stall_a, stall_b;
    logic [31:0]     busy_a, busy_b;
    logic [3:0]      cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int free_at [2][32];
    int perf [2];

    always #5 clk = ~clk;

    fwd_hazard_unit #(.PERF_W(4)) dut_a (
        .clk(clk), .rst(rst), .stg_regWrite(stg_regWrite), .stg_rd(stg_rd),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rs_used(ex_rs_used),
        .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .flush(flush),
        .fwd_sel(sel_a), .stall(stall_a), .sb_busy(busy_a),
        .stall_count(cnt_a)
    );

    fwd_hazard_unit #(.FWD_EN(1'b0), .PERF_W(4)) dut_b (
        .clk(clk), .rst(rst), .stg_regWrite(stg_regWrite), .stg_rd(stg_rd),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rs_used(ex_rs_used),
        .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .flush(flush),
        .fwd_sel(sel_b), .stall(stall_b), .sb_busy(busy_b),
        .stall_count(cnt_b)
    );

    task automatic lit(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit mt(int j, int k);
        return stg_regWrite[k] && stg_rd[k] != 0 &&
               stg_rd[k] == ex_rs[j] && ex_rs_used[j];
    endfunction

    // A register is pending while the current cycle is before its free cycle.
    function automatic bit mbusy(int i, int r);
        return r != 0 && cyc < free_at[i][r];
    endfunction

    function automatic int msel(int i, int j);
        if (i == 1) return 0;
        for (int k = 0; k < 2; k++) if (mt(j, k)) return k + 1;
        return 0;
    endfunction

    function automatic bit mstall(int i);
        bit sb = 1'b0;
        bit st = 1'b0;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 2; k++) if (mt(j, k)) st = 1'b1;
            if (ex_rs_used[j] && ex_rs[j] != 0 && mbusy(i, int'(ex_rs[j])))
                sb = 1'b1;
        end
        return ex_valid && (sb || (i == 1 && st));
    endfunction

    always @(posedge clk) begin
        bit s [2];
        bit a [2];
        for (int i = 0; i < 2; i++) begin
            s[i] = mstall(i);
            a[i] = mc_issue && ex_valid && !s[i] && !flush &&
                   mc_rd != 0 && mc_lat != 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (rst || flush) begin
                for (int r = 0; r < 32; r++) free_at[i][r] = 0;
            end else if (a[i]) begin
                free_at[i][mc_rd] = cyc + 1 + int'(mc_lat);
            end
            if (rst) perf[i] = 0;
            else if (s[i] && perf[i] < 15) perf[i]++;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] eb;
                for (int r = 0; r < 32; r++) eb[r] = mbusy(i, r);
                lit($sformatf("model_stall%0d", i),
                    i == 0 ? stall_a : stall_b, mstall(i));
                for (int j = 0; j < 2; j++)
                    lit($sformatf("model_sel%0d_%0d", i, j),
                        i == 0 ? sel_a[j] : sel_b[j], msel(i, j));
                lit($sformatf("model_busy%0d", i),
                    i == 0 ? busy_a : busy_b, eb);
                lit($sformatf("model_count%0d", i),
                    i == 0 ? cnt_a : cnt_b, perf[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stg_regWrite = '0;
        stg_rd       = '0;
        ex_valid     = 1'b0;
        ex_rs        = '0;
        ex_rs_used   = '0;
        mc_issue     = 1'b0;
        mc_rd        = '0;
        mc_lat       = '0;
        flush        = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        lit("reset_stall", stall_a, 0);
        lit("reset_sel", sel_a, 0);
        lit("reset_busy", busy_a, 0);
        lit("reset_count", cnt_a, 0);

        tick();
        ex_valid     = 1'b1;
        stg_regWrite = 2'b11;
        stg_rd[0]    = 5'd5;
        stg_rd[1]    = 5'd5;
        ex_rs[0]     = 5'd5;
        ex_rs[1]     = 5'd5;
        ex_rs_used   = 2'b01;
        #2;
        lit("fwd_youngest", sel_a[0], 1);
        lit("fwd_unused_src", sel_a[1], 0);
        tick();
        stg_regWrite = 2'b10;
        #2;
        lit("fwd_oldest", sel_a[0], 2);
        tick();
        stg_regWrite = 2'b11;
        stg_rd       = '0;
        ex_rs        = '0;
        #2;
        lit("fwd_x0", sel_a[0], 0);

        tick();
        stg_regWrite = 2'b10;
        stg_rd[1]    = 5'd4;
        ex_rs[0]     = 5'd4;
        ex_rs_used   = 2'b01;
        #2;
        lit("nofwd_stall", stall_b, 1);
        lit("nofwd_sel", sel_b[0], 0);
        lit("fwd_no_stall", stall_a, 0);
        tick();
        ex_rs_used = 2'b00;
        #2;
        lit("nofwd_unused", stall_b, 0);

        tick();
        idle();
        tick();
        ex_valid = 1'b1;
        mc_issue = 1'b1;
        mc_rd    = 5'd7;
        mc_lat   = 4'd3;
        tick();
        mc_issue   = 1'b0;
        ex_rs[0]   = 5'd7;
        ex_rs_used = 2'b01;
        #2;
        lit("cd_stall_t1", stall_a, 1);
        lit("cd_busy_t1", busy_a[7], 1);
        tick();
        tick();
        #2;
        lit("cd_stall_t3", stall_a, 1);
        tick();
        #2;
        lit("cd_stall_t4", stall_a, 0);
        lit("cd_busy_t4", busy_a[7], 0);
        lit("cd_count", cnt_a, 3);

        tick();
        ex_rs_used = 2'b00;
        mc_issue   = 1'b1;
        mc_rd      = 5'd9;
        mc_lat     = 4'd5;
        tick();
        mc_rd      = 5'd11;
        mc_lat     = 4'd3;
        ex_rs[0]   = 5'd9;
        ex_rs_used = 2'b01;
        #2;
        lit("waw_stall", stall_a, 1);
        tick();
        ex_rs_used = 2'b00;
        mc_rd      = 5'd9;
        mc_lat     = 4'd2;
        #2;
        lit("rejected_issue", busy_a[11], 0);
        tick();
        mc_issue = 1'b0;
        tick();
        #2;
        lit("waw_busy_last", busy_a[9], 1);
        tick();
        #2;
        lit("waw_busy_clear", busy_a[9], 0);

        tick();
        mc_issue = 1'b1;
        mc_rd    = 5'd3;
        mc_lat   = 4'd10;
        tick();
        mc_issue = 1'b0;
        tick();
        flush = 1'b1;
        #2;
        lit("flush_pre", busy_a[3], 1);
        tick();
        flush      = 1'b0;
        ex_rs[0]   = 5'd3;
        ex_rs_used = 2'b01;
        #2;
        lit("flush_busy", busy_a, 0);
        lit("flush_stall", stall_a, 0);

        tick();
        ex_rs_used = 2'b00;
        mc_issue   = 1'b1;
        mc_rd      = 5'd12;
        mc_lat     = 4'd8;
        tick();
        mc_issue   = 1'b0;
        ex_rs[0]   = 5'd12;
        ex_rs_used = 2'b01;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        lit("rst_busy_a", busy_a, 0);
        lit("rst_busy_b", busy_b, 0);
        lit("rst_count_a", cnt_a, 0);
        lit("rst_count_b", cnt_b, 0);
        lit("rst_stall", stall_a, 0);

        tick();
        stg_regWrite = 2'b01;
        stg_rd[0]    = 5'd6;
        ex_rs[0]     = 5'd6;
        ex_rs_used   = 2'b01;
        repeat (20) tick();
        #2;
        lit("sat_count_b", cnt_b, 15);
        lit("sat_count_a", cnt_a, 0);

        tick();
        idle();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
